if_seg: RTL and testbench

- Instruction-fetch stage of the pipelined CPU, directly upstream of the decode stage.
- Owns the PC and issues word fetches to instruction memory over a request/grant/response handshake.
- Presents fetched instruction (IRo) and its next-PC (NPCo) to decode, with a valid flag.
- Honours decode back-pressure (stall) and branch redirects from later stages; at most one outstanding fetch, plus a one-entry skid buffer.

---
 rtl/if_seg.sv | 144 ++++++++++++++
 tb/tb_if_seg.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/if_seg.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/gnt/rvalid
// handshake and hands instructions to decode through a one-entry skid buffer.
module if_seg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] NPCo,
    output logic [31:0] IRo,
    output logic        valid
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_DROP  = 2'd3;

    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] npc_q, npc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] skid_ir_q, skid_ir_d;
    logic [XLEN-1:0] skid_npc_q, skid_npc_d;

    logic [XLEN-1:0] pc_inc;
    logic            slot_free;
    logic            consumed;

    assign pc_inc    = pc_q + PC_STEP;
    assign consumed  = valid_q && !stall;
    assign slot_free = !valid_q || !stall;

    // Request is a pure decode of the registered state.
    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = {pc_q[XLEN-1:2], 2'b00};

    assign IRo   = ir_q;
    assign NPCo  = npc_q;
    assign valid = valid_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        npc_d      = npc_q;
        valid_d    = valid_q;
        skid_ir_d  = skid_ir_q;
        skid_npc_d = skid_npc_q;

        if (consumed) begin
            valid_d = 1'b0;
            ir_d    = NOP;
        end

        case (state_q)
            ST_FETCH: begin
                if (imem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    pc_d = pc_inc;
                    if (slot_free) begin
                        ir_d    = imem_rdata;
                        npc_d   = pc_inc;
                        valid_d = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        skid_ir_d  = imem_rdata;
                        skid_npc_d = pc_inc;
                        state_d    = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                // FULL is only entered with valid set, so !stall means consumed.
                if (!stall) begin
                    ir_d    = skid_ir_q;
                    npc_d   = skid_npc_q;
                    valid_d = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                if (imem_rvalid) begin
                    state_d = ST_FETCH;
                end
            end
        endcase

        // Redirect wins over everything above; any in-flight data is dropped.
        if (br_taken) begin
            pc_d       = br_target & WORD_MASK;
            valid_d    = 1'b0;
            ir_d       = NOP;
            npc_d      = npc_q;
            skid_ir_d  = skid_ir_q;
            skid_npc_d = skid_npc_q;
            case (state_q)
                ST_FETCH: state_d = imem_gnt ? ST_DROP : ST_FETCH;
                ST_WAIT:  state_d = imem_rvalid ? ST_FETCH : ST_DROP;
                ST_FULL:  state_d = ST_FETCH;
                default:  state_d = ST_DROP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC & WORD_MASK;
            ir_q       <= NOP;
            npc_q      <= '0;
            valid_q    <= 1'b0;
            skid_ir_q  <= '0;
            skid_npc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            npc_q      <= npc_d;
            valid_q    <= valid_d;
            skid_ir_q  <= skid_ir_d;
            skid_npc_q <= skid_npc_d;
        end
    end

endmodule

// File: tb/tb_if_seg.sv
// Directed cycle-vector bench for if_seg plus a randomized stall/grant
// scoreboard run that checks in-order, lossless instruction delivery.
module tb_if_seg;

    logic        clk = 1'b0;
    logic        rst, stall, br_taken, imem_gnt, imem_rvalid;
    logic [31:0] br_target, imem_rdata;
    logic        imem_req, valid;
    logic [31:0] imem_addr, NPCo, IRo;

    int n_cmp = 0;
    int n_bad = 0;

    if_seg #(.RESET_PC(32'h0000_0000), .NOP(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .NPCo(NPCo), .IRo(IRo), .valid(valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, br;
        logic [31:0] tgt;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ir, e_npc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic s, logic b, logic [31:0] t,
                                logic g, logic v, logic [31:0] d,
                                logic eq, logic [31:0] ea, logic ev,
                                logic [31:0] ei, logic [31:0] en);
        vec_t x;
        x.rst = r; x.stall = s; x.br = b; x.tgt = t; x.gnt = g; x.rv = v;
        x.rdata = d; x.e_req = eq; x.e_addr = ea; x.e_valid = ev;
        x.e_ir = ei; x.e_npc = en;
        return x;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic b,
                         input logic [31:0] t, input logic g, input logic v,
                         input logic [31:0] d);
        rst = r; stall = s; br_taken = b; br_target = t;
        imem_gnt = g; imem_rvalid = v; imem_rdata = d;
    endtask

    initial begin
        // rst stall br tgt gnt rv rdata | req addr valid IRo NPCo
        // Sequential fetch, zero-wait memory
        tbl.push_back(mk(1,0,0,0,0,0,0,                   1,32'h0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,                   0,32'h0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'h1111_0000,       1,32'h4,1,32'h1111_0000,32'h4));
        tbl.push_back(mk(0,0,0,0,1,0,0,                   0,32'h4,0,0,32'h4));
        tbl.push_back(mk(0,0,0,0,0,1,32'h1111_0004,       1,32'h8,1,32'h1111_0004,32'h8));
        tbl.push_back(mk(0,0,0,0,1,0,0,                   0,32'h8,0,0,32'h8));
        tbl.push_back(mk(0,0,0,0,0,1,32'h1111_0008,       1,32'hC,1,32'h1111_0008,32'hC));
        // Back-pressure into the skid buffer
        tbl.push_back(mk(1,0,0,0,0,0,0,                   1,32'h0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,                   0,32'h0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'hAAAA_0000,       1,32'h4,1,32'hAAAA_0000,32'h4));
        tbl.push_back(mk(0,1,0,0,1,0,0,                   0,32'h4,1,32'hAAAA_0000,32'h4));
        tbl.push_back(mk(0,1,0,0,0,1,32'hBBBB_0004,       0,32'h8,1,32'hAAAA_0000,32'h4));
        tbl.push_back(mk(0,1,0,0,0,0,0,                   0,32'h8,1,32'hAAAA_0000,32'h4));
        tbl.push_back(mk(0,0,0,0,0,0,0,                   1,32'h8,1,32'hBBBB_0004,32'h8));
        tbl.push_back(mk(0,0,0,0,1,0,0,                   0,32'h8,0,0,32'h8));
        tbl.push_back(mk(0,0,0,0,0,1,32'hCCCC_0008,       1,32'hC,1,32'hCCCC_0008,32'hC));
        // Redirect in WAIT before rvalid, stale response dropped
        tbl.push_back(mk(1,0,0,0,0,0,0,                   1,32'h0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,                   0,32'h0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'hAAAA_0000,       1,32'h4,1,32'hAAAA_0000,32'h4));
        tbl.push_back(mk(0,0,0,0,1,0,0,                   0,32'h4,0,0,32'h4));
        tbl.push_back(mk(0,0,1,32'h100,0,0,0,             0,32'h100,0,0,32'h4));
        tbl.push_back(mk(0,0,0,0,0,1,32'hDEAD_BEEF,       1,32'h100,0,0,32'h4));
        tbl.push_back(mk(0,0,0,0,1,0,0,                   0,32'h100,0,0,32'h4));
        tbl.push_back(mk(0,0,0,0,0,1,32'hDDDD_0100,       1,32'h104,1,32'hDDDD_0100,32'h104));
        // Redirect coincident with rvalid, then redirect while FULL
        tbl.push_back(mk(1,0,0,0,0,0,0,                   1,32'h0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,                   0,32'h0,0,0,0));
        tbl.push_back(mk(0,0,1,32'h40,0,1,32'hDEAD_0000,  1,32'h40,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,                   0,32'h40,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'hAAAA_0040,       1,32'h44,1,32'hAAAA_0040,32'h44));
        tbl.push_back(mk(0,1,0,0,1,0,0,                   0,32'h44,1,32'hAAAA_0040,32'h44));
        tbl.push_back(mk(0,1,0,0,0,1,32'hBBBB_0044,       0,32'h48,1,32'hAAAA_0040,32'h44));
        tbl.push_back(mk(0,1,1,32'h80,0,0,0,              1,32'h80,0,0,32'h44));
        tbl.push_back(mk(0,0,0,0,1,0,0,                   0,32'h80,0,0,32'h44));
        tbl.push_back(mk(0,0,0,0,0,1,32'hCCCC_0080,       1,32'h84,1,32'hCCCC_0080,32'h84));
        // Misaligned targets, redirect in DROP, PC wrap
        tbl.push_back(mk(1,0,0,0,0,0,0,                   1,32'h0,0,0,0));
        tbl.push_back(mk(0,0,1,32'h203,0,0,0,             1,32'h200,0,0,0));
        tbl.push_back(mk(0,0,1,32'hFFFF_FFFF,1,0,0,       0,32'hFFFF_FFFC,0,0,0));
        tbl.push_back(mk(0,0,1,32'hFFFF_FFFE,0,1,32'h5,   0,32'hFFFF_FFFC,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'h6,               1,32'hFFFF_FFFC,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,                   0,32'hFFFF_FFFC,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'hEEEE_FFFC,       1,32'h0,1,32'hEEEE_FFFC,32'h0));
        // Reset mid-WAIT with rvalid, then a stray rvalid in FETCH
        tbl.push_back(mk(1,0,0,0,0,0,0,                   1,32'h0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,                   0,32'h0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'hAAAA_0000,       1,32'h4,1,32'hAAAA_0000,32'h4));
        tbl.push_back(mk(0,1,0,0,1,0,0,                   0,32'h4,1,32'hAAAA_0000,32'h4));
        tbl.push_back(mk(1,1,0,0,0,1,32'hBBBB_0004,       1,32'h0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'h7777_7777,       1,32'h0,0,0,0));

        drive(1, 0, 0, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].tgt,
                  tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
            @(posedge clk);
            #1;
            chk("imem_req",  i, 32'(imem_req), 32'(tbl[i].e_req));
            chk("imem_addr", i, imem_addr,     tbl[i].e_addr);
            chk("valid",     i, 32'(valid),    32'(tbl[i].e_valid));
            chk("IRo",       i, IRo,           tbl[i].e_ir);
            chk("NPCo",      i, NPCo,          tbl[i].e_npc);
        end

        // Random stall/grant/latency against a reactive memory: every
        // instruction consumed must be the next sequential word, exactly once.
        begin
            logic        pend;
            logic [31:0] pend_addr;
            int          dly;
            logic [31:0] exp_pc;
            int          got;
            pend = 1'b0; pend_addr = '0; dly = 0; exp_pc = 32'h0; got = 0;
            drive(1, 0, 0, 0, 0, 0, 0);
            @(posedge clk);
            #1;
            for (int cyc = 0; cyc < 400; cyc++) begin
                logic s, g, v;
                logic [31:0] d;
                s = ($urandom_range(0, 9) < 4);
                g = 1'b0; v = 1'b0; d = 32'h0;
                if (pend) begin
                    if (dly == 0) begin
                        v = 1'b1; d = ~pend_addr; pend = 1'b0;
                    end else begin
                        dly--;
                    end
                end else if (imem_req && ($urandom_range(0, 3) != 0)) begin
                    g = 1'b1; pend = 1'b1; pend_addr = imem_addr;
                    dly = $urandom_range(0, 2);
                end
                if (valid && !s) begin
                    chk("seq_IRo",  got, IRo,  ~exp_pc);
                    chk("seq_NPCo", got, NPCo, exp_pc + 32'd4);
                    exp_pc = exp_pc + 32'd4;
                    got++;
                end
                drive(0, s, 0, 0, g, v, d);
                @(posedge clk);
                #1;
            end
            chk("seq_delivered_min", 0, 32'(got >= 25), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
